muldiv_hilo_unit: RTL and testbench

Iterative 32-bit multiply/divide unit that owns the HI/LO register pair. It sits beside the EX-stage ALU: it accepts MUL/DIV requests under the ALU's operation encoding and stalls the pipeline while running. The results are read back through a move-from-HI/LO port and written through a move-to-HI/LO port. The ALU's single-cycle multiply/divide is replaced by this unit.

---
 rtl/muldiv_pkg.sv | 23 ++
 rtl/muldiv_core.sv | 67 ++++++
 rtl/muldiv_hilo_unit.sv | 163 ++++++++++++++++
 tb/tb_muldiv_hilo_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants, opcodes and FSM state type for the iterative HI/LO multiply/divide unit.
package muldiv_pkg;

   localparam int WIDTH_DEF = 32;

   localparam logic [4:0] OP_MUL = 5'hf;
   localparam logic [4:0] OP_DIV = 5'h10;

   // A divide by zero returns an all-ones quotient.
   localparam logic [WIDTH_DEF-1:0] DIV_ZERO_LO = {WIDTH_DEF{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } state_e;

   function automatic logic [WIDTH_DEF-1:0] mag(input logic [WIDTH_DEF-1:0] v,
                                                input logic                  signed_en);
      return (signed_en && v[WIDTH_DEF-1]) ? -v : v;
   endfunction

endpackage

// File: rtl/muldiv_core.sv
// Datapath: 2*WIDTH shift register with one adder/subtractor, doing one shift-add (MUL)
// or restoring shift-subtract (DIV) iteration per step on unsigned magnitudes.
module muldiv_core
   import muldiv_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load_i,
   input  logic                 step_i,
   input  logic                 div_i,
   input  logic [WIDTH-1:0]     a_i,
   input  logic [WIDTH-1:0]     b_i,
   output logic [2*WIDTH-1:0]   acc_o
);

   logic [2*WIDTH-1:0] acc_q, acc_d, acc_step;
   logic [WIDTH-1:0]   b_q;
   logic               div_q;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_trial;
   logic [WIDTH:0]     div_diff;

   // MUL: add the multiplicand into the upper half when the low bit is set, then shift right.
   // DIV: shift left one bit into a WIDTH+1 trial remainder and keep the difference if no borrow.
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
      div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_diff  = div_trial - {1'b0, b_q};
      if (div_q) begin
         if (!div_diff[WIDTH]) begin
            acc_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
         end else begin
            acc_step = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
         end
      end else begin
         acc_step = {mul_sum, acc_q[WIDTH-1:1]};
      end
   end

   always_comb begin
      acc_d = acc_q;
      if (load_i) begin
         acc_d = {{WIDTH{1'b0}}, a_i};
      end else if (step_i) begin
         acc_d = acc_step;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q <= '0;
         b_q   <= '0;
         div_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         if (load_i) begin
            b_q   <= b_i;
            div_q <= div_i;
         end
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/muldiv_hilo_unit.sv
// Iterative MUL/DIV unit owning HI/LO: FSM, iteration counter, sign fix-up and move-to/from ports.
// Build option: define MULDIV_SIGNED_MUL_EN for two's-complement MUL (default is unsigned).
//
// Handshake: start is a request strobe sampled only in IDLE with a MUL/DIV opcode; busy is high
// from the accept edge until the fix-up edge, done pulses for one cycle once HI/LO hold the result.
module muldiv_hilo_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [4:0]        operation,
   input  logic [WIDTH-1:0]  Op1,
   input  logic [WIDTH-1:0]  Op2,
   input  logic              hi_we,
   input  logic              lo_we,
   input  logic [WIDTH-1:0]  wdata,
   input  logic              mf_sel,
   output logic [WIDTH-1:0]  mf_data,
   output logic              busy,
   output logic              done,
   output logic              div_zero,
   output logic [1:0]        state_dbg
);

   localparam int CW = $clog2(WIDTH);

   state_e             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic               done_q, done_d;
   logic               dz_q, dz_d;
   logic               div_q, neg_res_q, neg_rem_q, zero_q;
   logic [WIDTH-1:0]   op1_q;

   logic               accept, is_div, signed_op;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   fix_hi, fix_lo;

   assign is_div = (operation == OP_DIV);
   assign accept = (state_q == ST_IDLE) && start && ((operation == OP_MUL) || is_div);

`ifdef MULDIV_SIGNED_MUL_EN
   assign signed_op = 1'b1;
`else
   assign signed_op = is_div;
`endif

   assign a_mag = mag(Op1, signed_op);
   assign b_mag = mag(Op2, signed_op);

   muldiv_core #(.WIDTH(WIDTH)) u_core (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (accept),
      .step_i (state_q == ST_RUN),
      .div_i  (is_div),
      .a_i    (a_mag),
      .b_i    (b_mag),
      .acc_o  (acc)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_RUN;
               cnt_d   = CW'(WIDTH - 1);
            end
         end
         ST_RUN: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               state_d = ST_FIX;
            end
         end
         ST_FIX:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Magnitude result to signed result; MIN/-1 falls out naturally as 0x8000_0000 rem 0.
   always_comb begin
      fix_hi = acc[2*WIDTH-1:WIDTH];
      fix_lo = acc[WIDTH-1:0];
      if (div_q) begin
         if (zero_q) begin
            fix_hi = op1_q;
            fix_lo = WIDTH'(DIV_ZERO_LO);
         end else begin
            fix_lo = neg_res_q ? -acc[WIDTH-1:0]       : acc[WIDTH-1:0];
            fix_hi = neg_rem_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
         end
      end else begin
`ifdef MULDIV_SIGNED_MUL_EN
         {fix_hi, fix_lo} = neg_res_q ? -acc : acc;
`else
         {fix_hi, fix_lo} = acc;
`endif
      end
   end

   // Move-to writes only land in IDLE; FIX overwrites any value written on the accept edge.
   always_comb begin
      hi_d   = hi_q;
      lo_d   = lo_q;
      done_d = 1'b0;
      dz_d   = dz_q;
      if (state_q == ST_IDLE) begin
         if (hi_we)  hi_d = wdata;
         if (lo_we)  lo_d = wdata;
         if (accept) dz_d = 1'b0;
      end
      if (state_q == ST_FIX) begin
         hi_d   = fix_hi;
         lo_d   = fix_lo;
         done_d = 1'b1;
         if (div_q && zero_q) dz_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
         dz_q      <= 1'b0;
         div_q     <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         zero_q    <= 1'b0;
         op1_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
         dz_q    <= dz_d;
         if (accept) begin
            div_q     <= is_div;
            neg_res_q <= signed_op && (Op1[WIDTH-1] ^ Op2[WIDTH-1]);
            neg_rem_q <= is_div && Op1[WIDTH-1];
            zero_q    <= (Op2 == '0);
            op1_q     <= Op1;
         end
      end
   end

   assign mf_data   = mf_sel ? hi_q : lo_q;
   assign busy      = (state_q != ST_IDLE);
   assign done      = done_q;
   assign div_zero  = dz_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Directed self-checking bench for muldiv_hilo_unit: latency, done pulse, signed DIV, special
// cases, busy-time stimulus, mid-operation reset and the move-to/move-from path.
module tb_muldiv_hilo_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [4:0]  operation;
   logic [31:0] Op1, Op2;
   logic        hi_we, lo_we;
   logic [31:0] wdata;
   logic        mf_sel;
   logic [31:0] mf_data;
   logic        busy, done, div_zero;
   logic [1:0]  state_dbg;

   int checks = 0;
   int errors = 0;
   logic [63:0] exp_q[$];
   logic        dz_at_accept;

   muldiv_hilo_unit dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .operation (operation),
      .Op1       (Op1),
      .Op2       (Op2),
      .hi_we     (hi_we),
      .lo_we     (lo_we),
      .wdata     (wdata),
      .mf_sel    (mf_sel),
      .mf_data   (mf_data),
      .busy      (busy),
      .done      (done),
      .div_zero  (div_zero),
      .state_dbg (state_dbg)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
      mf_sel = 1'b1;
      #1 h = mf_data;
      mf_sel = 1'b0;
      #1 l = mf_data;
   endtask

   task automatic move_to(input logic is_hi, input logic [31:0] d);
      @(negedge clk);
      hi_we = is_hi;
      lo_we = !is_hi;
      wdata = d;
      @(negedge clk);
      hi_we = 1'b0;
      lo_we = 1'b0;
   endtask

   // Full operation: fixed 40-cycle window counts busy cycles and done pulses, then checks HI/LO.
   task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp);
      int          busy_cnt;
      int          done_cnt;
      logic [31:0] h, l;
      logic [63:0] e;
      exp_q.push_back(exp);
      @(negedge clk);
      start = 1'b1; operation = op; Op1 = a; Op2 = b;
      @(negedge clk);
      start = 1'b0;
      dz_at_accept = div_zero;
      busy_cnt = 0;
      done_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (busy) busy_cnt++;
         if (done) done_cnt++;
         @(negedge clk);
      end
      chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd33);
      chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
      read_hilo(h, l);
      e = exp_q.pop_front();
      chk({tag, "_hi"}, h, e[63:32]);
      chk({tag, "_lo"}, l, e[31:0]);
   endtask

   // Bounded wait for the in-flight operation to finish; expiry counts as a failure.
   task automatic wait_idle(input string tag);
      for (int i = 0; i < 60 && busy; i++) @(negedge clk);
      chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
      chk({tag, "_done_at_end"}, {31'd0, done}, 32'd1);
   endtask

   initial begin
      logic [31:0] h, l;
      int          dcnt;

      rst_n = 1'b0; start = 1'b0; operation = 5'h0; Op1 = '0; Op2 = '0;
      hi_we = 1'b0; lo_we = 1'b0; wdata = '0; mf_sel = 1'b0;
      repeat (3) @(negedge clk);
      read_hilo(h, l);
      chk("reset_hi", h, 32'h0);
      chk("reset_lo", l, 32'h0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      chk("reset_div_zero", {31'd0, div_zero}, 32'd0);
      chk("reset_state", {30'd0, state_dbg}, 32'd0);
      rst_n = 1'b1;

      // Move-to path
      move_to(1'b1, 32'hDEAD_BEEF);
      read_hilo(h, l);
      chk("mthi", h, 32'hDEAD_BEEF);
      move_to(1'b0, 32'h0000_00A5);
      read_hilo(h, l);
      chk("mtlo", l, 32'h0000_00A5);
      chk("mtlo_hi_kept", h, 32'hDEAD_BEEF);

      // Unknown opcode is ignored
      @(negedge clk);
      start = 1'b1; operation = 5'h0e; Op1 = 32'd1; Op2 = 32'd1;
      @(negedge clk);
      start = 1'b0;
      chk("bad_op_busy", {31'd0, busy}, 32'd0);

      // Busy-time stimulus: late start and hi_we are both dropped
      @(negedge clk);
      start = 1'b1; operation = 5'hf; Op1 = 32'd3; Op2 = 32'd5;
      @(negedge clk);
      start = 1'b0;
      chk("busy_state_run", {30'd0, state_dbg}, 32'd1);
      read_hilo(h, l);
      chk("busy_preop_hi", h, 32'hDEAD_BEEF);
      chk("busy_preop_lo", l, 32'h0000_00A5);
      repeat (4) @(negedge clk);
      start = 1'b1; Op1 = 32'd7; Op2 = 32'd9; hi_we = 1'b1; wdata = 32'h5555_5555;
      @(negedge clk);
      start = 1'b0; hi_we = 1'b0;
      read_hilo(h, l);
      chk("busy_hi_we_dropped", h, 32'hDEAD_BEEF);
      wait_idle("busy_mul");
      read_hilo(h, l);
      chk("busy_mul_hi", h, 32'h0);
      chk("busy_mul_lo", l, 32'd15);
      @(negedge clk);
      chk("busy_mul_done_drop", {31'd0, done}, 32'd0);
      chk("busy_mul_no_requeue", {31'd0, busy}, 32'd0);

      // Same-cycle start + hi_we in IDLE: write lands, result overwrites later
      @(negedge clk);
      start = 1'b1; operation = 5'hf; Op1 = 32'd2; Op2 = 32'd3;
      hi_we = 1'b1; wdata = 32'h1111_1111;
      @(negedge clk);
      start = 1'b0; hi_we = 1'b0;
      read_hilo(h, l);
      chk("same_cycle_hi_write", h, 32'h1111_1111);
      wait_idle("same_cycle");
      read_hilo(h, l);
      chk("same_cycle_hi", h, 32'h0);
      chk("same_cycle_lo", l, 32'd6);

      // Main function
      run_op("mul_3x5", 5'hf, 32'd3, 32'd5, {32'h0, 32'd15});
      run_op("mul_shift", 5'hf, 32'h1234_5678, 32'h10, {32'h1, 32'h2345_6780});
`ifdef MULDIV_SIGNED_MUL_EN
      run_op("mul_ffff", 5'hf, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'h0, 32'h1});
      run_op("mul_neg", 5'hf, 32'hFFFF_FFFD, 32'd4, {32'hFFFF_FFFF, 32'hFFFF_FFF4});
`else
      run_op("mul_ffff", 5'hf, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h1});
      run_op("mul_neg", 5'hf, 32'hFFFF_FFFD, 32'd4, {32'h3, 32'hFFFF_FFF4});
`endif
      run_op("div_100_7", 5'h10, 32'd100, 32'd7, {32'd2, 32'd14});
      run_op("div_m7_2", 5'h10, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      run_op("div_7_m2", 5'h10, 32'd7, 32'hFFFF_FFFE, {32'h1, 32'hFFFF_FFFD});
      run_op("div_zero", 5'h10, 32'h1234, 32'h0, {32'h1234, 32'hFFFF_FFFF});
      chk("div_zero_flag_set", {31'd0, div_zero}, 32'd1);
      run_op("div_ovf", 5'h10, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000});
      chk("div_zero_clr_on_start", {31'd0, dz_at_accept}, 32'd0);
      chk("div_zero_stays_clr", {31'd0, div_zero}, 32'd0);

      // Mid-operation reset
      move_to(1'b1, 32'h0000_ABCD);
      @(negedge clk);
      start = 1'b1; operation = 5'hf; Op1 = 32'h1234_5678; Op2 = 32'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      read_hilo(h, l);
      chk("rst_mid_busy", {31'd0, busy}, 32'd0);
      chk("rst_mid_hi", h, 32'h0);
      chk("rst_mid_lo", l, 32'h0);
      dcnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) dcnt++;
         @(negedge clk);
      end
      chk("rst_mid_no_done", 32'(dcnt), 32'd0);
      chk("rst_mid_idle", {30'd0, state_dbg}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
